// File: rtl/key_select_pkg.sv
// Shared types and constants for the pushbutton select controller.
package key_select_pkg;

    // Debounce FSM state encoding (one FSM per key channel).
    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        PRESS_CHK   = 2'd1,
        HELD        = 2'd2,
        RELEASE_CHK = 2'd3
    } key_state_t;

    // 10 ms of stable level at 50 MHz.
    localparam int DEBOUNCE_DEFAULT = 500000;

endpackage

// File: rtl/key_select_ctrl_if.sv
// Board-side bundle for key_select_ctrl: raw keys in, select/press/held out,
// plus the per-channel FSM state for observation.
// There is no backpressure anywhere: press is a one-cycle strobe that acts as
// a valid with an implied always-ready consumer, and select/held are levels
// that are valid on every cycle.
interface key_select_ctrl_if;
    import key_select_pkg::*;

    logic       key0;
    logic       key1;
    logic [1:0] select;
    logic [1:0] press;
    logic [1:0] held;
    key_state_t state0;
    key_state_t state1;

    modport master (
        output key0, key1,
        input  select, press, held, state0, state1
    );

    modport slave (
        input  key0, key1,
        output select, press, held, state0, state1
    );

endinterface

// File: rtl/key_debounce.sv
// One pushbutton channel: two-flop synchronizer, debounce FSM with stable-level
// counter, debounced held level and a registered one-cycle press pulse.
// press_set is the combinational "a press is accepted on this edge" flag, so
// the parent can update select on the same edge that raises press.
module key_debounce
    import key_select_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key,
    output logic       held,
    output logic       press,
    output logic       press_set,
    output key_state_t state
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             s;
    key_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q;

    // Synchronize the inverted (pressed = 1) key level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= 2'b00;
        else     sync_q <= {sync_q[0], ~key};
    end

    assign s = sync_q[1];

    // State, counter and press pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RELEASED;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            press_q <= press_set;
        end
    end

    // Next-state: any level change shorter than the window restarts the check.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_set = 1'b0;
        case (state_q)
            RELEASED: begin
                if (s) begin
                    state_d = PRESS_CHK;
                    cnt_d   = '0;
                end
            end
            PRESS_CHK: begin
                if (!s) begin
                    state_d = RELEASED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = HELD;
                    press_set = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                if (!s) begin
                    state_d = RELEASE_CHK;
                    cnt_d   = '0;
                end
            end
            RELEASE_CHK: begin
                if (s) begin
                    state_d = HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RELEASED;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = RELEASED;
        endcase
    end

    assign held  = (state_q == HELD) || (state_q == RELEASE_CHK);
    assign press = press_q;
    assign state = state_q;

endmodule

// File: rtl/key_select_ctrl.sv
// Pushbutton controller: two debounced key channels driving the select toggle
// register. Optional macro KEY_SELECT_BOTH_CLEAR_EN clears select when a press
// coincides with a press or held level on the other key.
module key_select_ctrl
    import key_select_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic              clk,
    input  logic              rst,
    key_select_ctrl_if.slave  bus
);

    logic [1:0] held_w;
    logic [1:0] press_w;
    logic [1:0] press_set;
    logic [1:0] sel_q, sel_d;

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_key0 (
        .clk       (clk),
        .rst       (rst),
        .key       (bus.key0),
        .held      (held_w[0]),
        .press     (press_w[0]),
        .press_set (press_set[0]),
        .state     (bus.state0)
    );

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_key1 (
        .clk       (clk),
        .rst       (rst),
        .key       (bus.key1),
        .held      (held_w[1]),
        .press     (press_w[1]),
        .press_set (press_set[1]),
        .state     (bus.state1)
    );

    // Next select: toggle per accepted press, or clear on overlapping keys.
    always_comb begin
        sel_d = sel_q ^ press_set;
`ifdef KEY_SELECT_BOTH_CLEAR_EN
        if ((press_set[0] && (press_set[1] || held_w[1])) ||
            (press_set[1] && (press_set[0] || held_w[0])))
            sel_d = 2'b00;
`endif
    end

    // Select register, updated on the same edge that raises press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sel_q <= 2'b00;
        else     sel_q <= sel_d;
    end

    assign bus.select = sel_q;
    assign bus.press  = press_w;
    assign bus.held   = held_w;

endmodule
